// File: rtl/frame_pkg.sv
// Shared constants and types for the frame-buffer read sequencer.
package frame_pkg;

  localparam int unsigned H_ACT     = 480;
  localparam int unsigned V_ACT     = 272;
  localparam int unsigned FRAME_PIX = H_ACT * V_ACT;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned DATA_W    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Stream markers that travel with each pixel through the skid FIFO
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } mark_s;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO absorbing the buffer read latency; flush clears pointers.
module rd_skid_fifo #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = i_pop && (count_q != 2'd0);
  assign do_push = i_push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (i_flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign o_count = count_q;
  assign o_empty = (count_q == 2'd0);
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_rd_sched.sv
// Walks the frame buffer read port once per frame-ready pulse and streams
// pixels downstream with SOF/EOL/EOF markers over valid/ready.
module frame_rd_sched #(
  parameter int unsigned DATA_W = frame_pkg::DATA_W,
  parameter int unsigned ADDR_W = frame_pkg::ADDR_W,
  parameter int unsigned H_ACT  = frame_pkg::H_ACT,
  parameter int unsigned V_ACT  = frame_pkg::V_ACT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int unsigned FRAME_PIX = H_ACT * V_ACT;
  localparam int unsigned X_W       = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned Y_W       = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned ENT_W     = DATA_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(V_ACT - 1);

  frame_pkg::state_e state_q, state_d;
  frame_pkg::mark_s  mark_q, mark_d, mark_iss, head_mark;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic              rd_en_c;
  logic              pop;
  logic [2:0]        occ;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  rd_skid_fifo #(
    .WIDTH(ENT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_abort),
    .i_push  (inflight_q),
    .i_data  ({mark_q, i_rd_data}),
    .i_pop   (pop),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

  // Occupancy after this cycle's pop: FIFO entries plus the read still in flight
  assign pop     = !fifo_empty && i_pix_ready;
  assign occ     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_en_c = (state_q == frame_pkg::RUN) && (occ < 3'd2);

  assign mark_iss.sof = (x_q == '0) && (y_q == '0);
  assign mark_iss.eol = (x_q == LAST_X);
  assign mark_iss.eof = (x_q == LAST_X) && (y_q == LAST_Y);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    mark_d     = mark_q;
    inflight_d = rd_en_c;
    done_d     = 1'b0;
    ovr_d      = i_start && (state_q != frame_pkg::IDLE);

    if (rd_en_c) begin
      mark_d = mark_iss;
      if (addr_q != LAST_ADDR) begin
        addr_d = addr_q + ADDR_W'(1);
        if (x_q == LAST_X) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
    end

    unique case (state_q)
      frame_pkg::IDLE: begin
        if (i_start) begin
          state_d = frame_pkg::RUN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      frame_pkg::RUN: begin
        if (rd_en_c && (addr_q == LAST_ADDR)) begin
          state_d = frame_pkg::DRAIN;
        end
      end
      frame_pkg::DRAIN: begin
        // Nothing in flight and the FIFO empties this cycle
        if (!inflight_q && (fifo_count == 2'(pop))) begin
          state_d = frame_pkg::IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = frame_pkg::IDLE;
    endcase

    if (i_abort) begin
      state_d    = frame_pkg::IDLE;
      addr_d     = '0;
      x_d        = '0;
      y_d        = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= frame_pkg::IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mark_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mark_q     <= mark_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign head_mark    = frame_pkg::mark_s'(fifo_head[ENT_W-1:DATA_W]);
  assign o_rd_en      = rd_en_c;
  assign o_rd_addr    = addr_q;
  assign o_pix_valid  = !fifo_empty;
  assign o_pix_data   = fifo_head[DATA_W-1:0];
  assign o_sof        = !fifo_empty && head_mark.sof;
  assign o_eol        = !fifo_empty && head_mark.eol;
  assign o_eof        = !fifo_empty && head_mark.eof;
  assign o_busy       = (state_q != frame_pkg::IDLE);
  assign o_frame_done = done_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_frame_rd_sched.sv
// Randomized bench for frame_rd_sched on a 4x3 frame, checked every cycle
// against a count-based stream model plus literal timing expectations.
module tb_frame_rd_sched;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 17;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int          FP = int'(H * V);

  logic          clk = 1'b0;
  logic          rst_n, start, abort, ready;
  logic [DW-1:0] rd_data;
  logic          rd_en, pix_valid, sof, eol, eof, busy, frame_done, overrun;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] pix_data;

  frame_rd_sched #(
    .DATA_W(DW), .ADDR_W(AW), .H_ACT(H), .V_ACT(V)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_pix_valid(pix_valid), .i_pix_ready(ready), .o_pix_data(pix_data),
    .o_sof(sof), .o_eol(eol), .o_eof(eof), .o_busy(busy),
    .o_frame_done(frame_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: reads issued, reads whose data has landed, pixels popped
  bit m_act = 1'b0;
  int m_iss = 0, m_arr = 0, m_pop = 0;
  bit e_done = 1'b0, e_ovr = 1'b0;

  // Observation log for literal expectations
  int cyc = 0, t0 = 0;
  int l_first_rd, l_last_rd, l_n_rd, l_first_addr, l_first_val, l_last_val;
  int l_pop, l_done, l_done_cyc, l_ovr, l_stall_rd;
  bit in_stall = 1'b0;
  logic [31:0] sof_bits, eol_bits, eof_bits;

  // Buffer model: registered read, data = address, garbage when not read
  bit            pend_en = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  always @(posedge clk) begin
    #1;
    rd_data = pend_en ? DW'(pend_addr) : DW'($urandom);
  end

  always @(negedge clk) begin
    bit ev, pn, er, nx_done, nx_ovr;
    if (!rst_n) begin
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_valid", 32'(pix_valid), 0);
      check("rst_data", 32'(pix_data), 0);
      check("rst_flags", {29'd0, sof, eol, eof}, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done_ovr", {30'd0, frame_done, overrun}, 0);
      m_act = 0; m_iss = 0; m_arr = 0; m_pop = 0; e_done = 0; e_ovr = 0;
    end else begin
      ev = (m_arr > m_pop);
      pn = ev && ready;
      er = m_act && (m_iss < FP) && ((m_iss - m_pop - int'(pn)) < 2);
      check("busy", 32'(busy), 32'(m_act));
      check("rd_en", 32'(rd_en), 32'(er));
      check("pix_valid", 32'(pix_valid), 32'(ev));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("overrun", 32'(overrun), 32'(e_ovr));
      if (er && rd_en) check("rd_addr", 32'(rd_addr), 32'(m_iss));
      if (ev && pix_valid) begin
        check("pix_data", 32'(pix_data), 32'(m_pop));
        check("sof", 32'(sof), 32'(m_pop == 0));
        check("eol", 32'(eol), 32'((m_pop % int'(H)) == int'(H) - 1));
        check("eof", 32'(eof), 32'(m_pop == FP - 1));
      end
      nx_done = 0;
      nx_ovr  = start && m_act;
      if (abort) begin
        m_act = 0; m_iss = 0; m_arr = 0; m_pop = 0;
      end else if (m_act) begin
        m_arr = m_iss;
        if (er) m_iss++;
        if (pn) m_pop++;
        if (m_pop == FP) begin
          m_act = 0; nx_done = 1; m_iss = 0; m_arr = 0; m_pop = 0;
        end
      end else if (start) begin
        m_act = 1; m_iss = 0; m_arr = 0; m_pop = 0;
      end
      e_done = nx_done;
      e_ovr  = nx_ovr;
    end
    if (rd_en) begin
      if (l_first_rd < 0) begin l_first_rd = cyc - t0; l_first_addr = int'(rd_addr); end
      l_last_rd = cyc - t0;
      l_n_rd++;
      if (in_stall) l_stall_rd++;
    end
    if (pix_valid) begin
      if (l_first_val < 0) l_first_val = cyc - t0;
      l_last_val = cyc - t0;
    end
    if (pix_valid && ready) begin
      if (l_pop < 32) begin
        sof_bits[l_pop] = sof; eol_bits[l_pop] = eol; eof_bits[l_pop] = eof;
      end
      l_pop++;
    end
    if (frame_done) begin
      if (l_done_cyc < 0) l_done_cyc = cyc - t0;
      l_done++;
    end
    if (overrun) l_ovr++;
    pend_en   = rd_en;
    pend_addr = rd_addr;
    cyc++;
  end

  task automatic clear_log();
    t0 = cyc;
    l_first_rd = -1; l_last_rd = -1; l_n_rd = 0; l_first_addr = -1;
    l_first_val = -1; l_last_val = -1; l_pop = 0; l_done = 0; l_done_cyc = -1;
    l_ovr = 0; l_stall_rd = 0;
    sof_bits = '0; eol_bits = '0; eof_bits = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    int n = 0;
    while ((cyc < t0 + c) && (n < 200)) begin step(); n++; end
    check("goto_timeout", 32'(cyc - t0), 32'(c));
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit rnd);
    int n = 0;
    while ((l_done < target) && (n < 600)) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("done_timeout", 32'(l_done), 32'(target));
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while ((l_pop < target) && (n < 200)) begin step(); n++; end
    check("pop_timeout", 32'(l_pop), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; rd_data = '0;
    clear_log();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Continuous ready: exact cycle timing and marker positions
    ready = 1'b1;
    clear_log();
    pulse_start();
    wait_done(1, 1'b0);
    check("t1_first_rd", 32'(l_first_rd), 1);
    check("t1_last_rd", 32'(l_last_rd), 12);
    check("t1_n_rd", 32'(l_n_rd), 12);
    check("t1_first_val", 32'(l_first_val), 3);
    check("t1_last_val", 32'(l_last_val), 14);
    check("t1_done_cyc", 32'(l_done_cyc), 15);
    check("t1_sof_bits", sof_bits, 32'h001);
    check("t1_eol_bits", eol_bits, 32'h888);
    check("t1_eof_bits", eof_bits, 32'h800);
    repeat (3) step();

    // Ten-cycle stall mid-line
    clear_log();
    pulse_start();
    wait_pops(5);
    ready = 1'b0; in_stall = 1'b1;
    repeat (10) step();
    in_stall = 1'b0; ready = 1'b1;
    wait_done(1, 1'b0);
    check("t2_stall_rd", 32'(l_stall_rd), 0);
    check("t2_n_rd", 32'(l_n_rd), 12);
    check("t2_pops", 32'(l_pop), 12);
    repeat (3) step();

    // Start during RUN and in the last-pop cycle, then in the done cycle
    clear_log();
    pulse_start();
    goto_cyc(5);
    pulse_start();
    goto_cyc(14);
    pulse_start();
    check("t3_done_now", 32'(frame_done), 1);
    pulse_start();
    wait_done(2, 1'b0);
    check("t3_ovr", 32'(l_ovr), 2);
    check("t3_done_cyc", 32'(l_done_cyc), 15);
    check("t3_pops", 32'(l_pop), 24);
    repeat (3) step();

    // Abort after five pixels, then restart
    clear_log();
    pulse_start();
    wait_pops(5);
    abort = 1'b1; step(); abort = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_valid", 32'(pix_valid), 0);
    repeat (5) step();
    check("t4_no_done", 32'(l_done), 0);
    clear_log();
    pulse_start();
    wait_done(1, 1'b0);
    check("t4_first_addr", 32'(l_first_addr), 0);
    check("t4_sof_first", 32'(sof_bits[0]), 1);
    repeat (3) step();

    // Random back-pressure across several frames
    clear_log();
    for (int f = 1; f <= 5; f++) begin
      pulse_start();
      wait_done(f, 1'b1);
    end
    check("t5_frames", 32'(l_done), 5);
    check("t5_pops", 32'(l_pop), 60);
    ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset mid-frame
    clear_log();
    pulse_start();
    goto_cyc(7);
    rst_n = 1'b0;
    #1;
    check("t6_rd_en", 32'(rd_en), 0);
    check("t6_addr", 32'(rd_addr), 0);
    check("t6_valid", 32'(pix_valid), 0);
    check("t6_data", 32'(pix_data), 0);
    check("t6_busy", 32'(busy), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_log();
    pulse_start();
    wait_done(1, 1'b0);
    check("t6_pops", 32'(l_pop), 12);
    check("t6_first_addr", 32'(l_first_addr), 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_rd_sched.md
# frame_rd_sched

Read-side sequencer for the double-buffered camera input frame buffer. On a frame-ready pulse it walks the read port through addresses 0 … H_ACT·V_ACT−1, absorbs the buffer's 1-cycle read latency, and delivers pixels to the downstream window/filter stage over a valid/ready stream with SOF/EOL/EOF markers. It sits between the input buffer's read port and the filter pipeline, in the 100 MHz processing domain.

## Interface
- `DATA_W`, 24: pixel width (RGB888 from the buffer's read mux)
- `ADDR_W`, 17: buffer address width
- `H_ACT`, 480: pixels per line
- `V_ACT`, 272: lines per frame
- `i_clk`  in  1  processing clock; single clock domain
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  frame-ready pulse, one cycle, already synchronized to `i_clk`
- `i_abort`  in  1  synchronous abort; returns the block to IDLE
- `o_rd_en`  out  1  buffer read enable
- `o_rd_addr`  out  ADDR_W  buffer read address
- `i_rd_data`  in  DATA_W  buffer read data, valid the cycle after `o_rd_en`
- `o_pix_valid`  out  1  stream valid
- `i_pix_ready`  in  1  stream ready
- `o_pix_data`  out  DATA_W  pixel
- `o_sof` / `o_eol` / `o_eof`  out  1 each  first pixel / last pixel of line / last pixel of frame; qualified by `o_pix_valid`
- `o_busy`  out  1  high when state ≠ IDLE
- `o_frame_done`  out  1  one-cycle pulse at frame completion
- `o_overrun`  out  1  one-cycle pulse when `i_start` arrives while not IDLE

## Operation
- States:
  - IDLE → RUN on `i_start`.
  - RUN → DRAIN in the cycle after the read at address FRAME_PIX−1 is issued.
  - DRAIN → IDLE on the first cycle with no reads in flight and an empty FIFO.
- Address and position:
  - `o_rd_addr` increments by 1 per issued read. It is not incremented or wrapped after FRAME_PIX−1.
  - x counter (0 … H_ACT−1) and y counter (0 … V_ACT−1) track the position of each issued read.
- Marker flags are computed at issue time and travel with the data:
  - sof = (x==0 && y==0)
  - eol = (x==H_ACT−1)
  - eof = eol && (y==V_ACT−1)
- Output buffering:
  - 2-entry FIFO holds {sof, eol, eof, data}.
  - A single `inflight` bit marks a read issued last cycle.
  - The returning read is written into the FIFO unconditionally, one cycle after issue.
- Issue rule: `o_rd_en` = RUN && (fifo_count + inflight − pop) < 2, where pop = `o_pix_valid` && `i_pix_ready`. This sustains one pixel per cycle under continuous ready and never overflows the FIFO.
- Output stream:
  - `o_pix_valid` = fifo not empty.
  - Data and flags come from the FIFO head.
  - Data and flags are held stable while valid && !ready.
- `i_start` while not IDLE:
  - start is ignored;
  - `o_overrun` pulses;
  - the frame in progress is unaffected.
- `i_abort`:
  - next cycle: state = IDLE, FIFO is flushed, `inflight` = 0, counters = 0;
  - no `o_frame_done` pulse;
  - abort takes priority over start in the same cycle.
- The block does not switch buffer banks; bank selection stays in the buffer.

## Timing
- Reset values: `o_rd_en`, `o_pix_valid`, `o_sof`, `o_eol`, `o_eof`, `o_busy`, `o_frame_done`, `o_overrun` = 0; `o_rd_addr` = 0; `o_pix_data` = 0; state = IDLE; FIFO empty.
- With `i_start` in cycle 0 and ready held high:
  - first `o_rd_en` in cycle 1 (addr 0);
  - `i_rd_data` sampled at the end of cycle 2;
  - first `o_pix_valid` in cycle 3;
  - last `o_rd_en` in cycle FRAME_PIX;
  - last pop in cycle FRAME_PIX+2;
  - `o_frame_done` and return to IDLE in cycle FRAME_PIX+3.
- `i_start` in the cycle `o_frame_done` is high is accepted (state is IDLE).
- `i_start` one cycle earlier raises `o_overrun`.
- Read latency is fixed at 1 cycle. FIFO depth 2 is the minimum for full throughput with this latency.
- Under stalls, `o_rd_en` deasserts within the same cycle the issue rule fails. No read is ever issued without FIFO space.
- Mid-operation asynchronous reset: all state clears immediately. Outputs go to their reset values while `i_rst_n` is low.

## Structure
- Shared package `frame_pkg` holds:
  - H_ACT, V_ACT, FRAME_PIX = H_ACT·V_ACT;
  - ADDR_W, DATA_W;
  - state encoding (IDLE = 0, RUN = 1, DRAIN = 2).
- One sub-module, `rd_skid_fifo`: a 2-entry synchronous FIFO, width DATA_W+3, with push, pop, count, empty and head outputs.
- The top level holds the FSM, the counters, the issue rule and the marker generation.

## Test plan
- Continuous ready, small frame (H_ACT=4, V_ACT=3):
  - `i_start` at cycle 0 → `o_rd_en` cycles 1–12, addresses 0–11;
  - `o_pix_valid` cycles 3–14;
  - `o_eol` at pixels 3, 7, 11; `o_sof` at pixel 0; `o_eof` at pixel 11;
  - `o_frame_done` at cycle 15.
- Random `i_pix_ready` (50%), buffer model returns data = address → output data sequence is exactly 0…FRAME_PIX−1, no duplicates, no drops; FIFO count never exceeds 2.
- `i_pix_ready` low for 10 cycles mid-line → `o_rd_en` stops within one cycle; output data and flags stay stable during the stall; the stream resumes with no gap in the address sequence.
- `i_start` during RUN, and again in the cycle before `o_frame_done` → `o_overrun` pulses each time; the frame completes normally; a start in the `o_frame_done` cycle begins a new frame at addr 0.
- `i_abort` after 5 pixels → next cycle `o_busy` = 0 and `o_pix_valid` = 0; no `o_frame_done`; a following `i_start` restarts at addr 0 with `o_sof`.
- `i_rst_n` asserted mid-frame → all outputs at their reset values immediately; after release and `i_start`, the full frame runs cleanly.
